// File: rtl/scaler_cmd_ctrl_pkg.sv
// Shared definitions for the scaler command controller.
// Holds the default clamp/step/reset values for the scaler ratio and the
// hold-to-repeat button FSM state encoding.
package scaler_cmd_ctrl_pkg;

  localparam int unsigned ScaleMinDef  = 110;
  localparam int unsigned ScaleMaxDef  = 400;
  localparam int unsigned ScaleStepDef = 10;
  localparam int unsigned ScaleRstDef  = 110;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } btn_state_e;

endpackage

// File: rtl/scaler_cmd_ctrl_btn_repeat.sv
// Button front-end with hold-to-repeat.
// Synchronises an asynchronous button level (d1,d2 plus a d3 edge stage) and
// emits single-cycle step pulses: one on press, one after HOLD_CYC cycles of
// holding, then one every REPEAT_CYC cycles while still held.
// Ports:
//   i_Sys_clk     system clock
//   i_Rst_n       synchronous active-low reset
//   i_Btn         asynchronous button level, high = pressed
//   i_Force_idle  hold the FSM in idle and suppress steps
//   o_Step        1-cycle step request
//   o_Level       synchronised button level (d2)
module scaler_cmd_ctrl_btn_repeat
  import scaler_cmd_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic i_Sys_clk,
  input  logic i_Rst_n,
  input  logic i_Btn,
  input  logic i_Force_idle,
  output logic o_Step,
  output logic o_Level
);

  logic        d1_q, d2_q, d3_q;
  logic        rise;
  btn_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;

  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      d3_q    <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      d1_q    <= i_Btn;
      d2_q    <= d1_q;
      d3_q    <= d2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise    = d2_q & ~d3_q;
  assign o_Level = d2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_Step  = 1'b0;
    // Release, or both buttons down, always returns to idle. Idle only leaves on
    // a fresh rising edge, so a button still held after a forced idle stays quiet.
    if (i_Force_idle || !d2_q) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StHold;
            cnt_d   = '0;
            o_Step  = 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == HOLD_CYC - 1) begin
            state_d = StRepeat;
            cnt_d   = '0;
            o_Step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StRepeat: begin
          if (cnt_q == REPEAT_CYC - 1) begin
            cnt_d  = '0;
            o_Step = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/scaler_cmd_ctrl.sv
// Scaler ratio command controller.
// Arbitrates front-panel up/down buttons and a host absolute-set request into
// a clamped staged target, and commits that target to the datapath only on a
// frame-sync rising edge.
// Ports:
//   i_Sys_clk        system clock
//   i_Rst_n          synchronous active-low reset
//   i_External_sync  async frame sync, rising edge commits the target
//   i_Btn_up         async up button, high = pressed
//   i_Btn_down       async down button, high = pressed
//   i_Host_valid     host set request
//   i_Host_scaler    host requested value
//   o_Host_ready     host request accepted when valid & ready
//   o_Host_err       1-cycle pulse: accepted host value was clamped
//   o_Cmd_scaler     committed scaler value
//   o_Pending        staged target differs from o_Cmd_scaler (registered)
//   o_Update_pulse   1-cycle pulse when a commit changed o_Cmd_scaler
module scaler_cmd_ctrl
  import scaler_cmd_ctrl_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter int unsigned SCALE_MIN  = ScaleMinDef,
  parameter int unsigned SCALE_MAX  = ScaleMaxDef,
  parameter int unsigned SCALE_STEP = ScaleStepDef,
  parameter int unsigned SCALE_RST  = ScaleRstDef,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic         i_Sys_clk,
  input  logic         i_Rst_n,
  input  logic         i_External_sync,
  input  logic         i_Btn_up,
  input  logic         i_Btn_down,
  input  logic         i_Host_valid,
  input  logic [W-1:0] i_Host_scaler,
  output logic         o_Host_ready,
  output logic         o_Host_err,
  output logic [W-1:0] o_Cmd_scaler,
  output logic         o_Pending,
  output logic         o_Update_pulse
);

  localparam logic [W-1:0] MinV  = SCALE_MIN[W-1:0];
  localparam logic [W-1:0] MaxV  = SCALE_MAX[W-1:0];
  localparam logic [W-1:0] StepV = SCALE_STEP[W-1:0];
  localparam logic [W-1:0] RstV  = SCALE_RST[W-1:0];
  localparam logic [W:0]   MinX  = SCALE_MIN[W:0];
  localparam logic [W:0]   MaxX  = SCALE_MAX[W:0];
  localparam logic [W:0]   StepX = SCALE_STEP[W:0];

  logic         up_step, dn_step, up_level, dn_level, both_held;
  logic         s1_q, s2_q, s3_q, commit;
  logic [W-1:0] target_q, target_d, cmd_q, cmd_d;
  logic         ready_q, ready_d, busy_q, busy_d;
  logic         err_q, err_d, pending_q, pending_d, upd_q, upd_d;
  logic         accept, clamped;
  logic [W:0]   tgt_x, host_x, up_sum;
  logic [W-1:0] up_val, dn_val, host_val;

  assign both_held = up_level & dn_level;

  scaler_cmd_ctrl_btn_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_btn_up (
    .i_Sys_clk    (i_Sys_clk),
    .i_Rst_n      (i_Rst_n),
    .i_Btn        (i_Btn_up),
    .i_Force_idle (both_held),
    .o_Step       (up_step),
    .o_Level      (up_level)
  );

  scaler_cmd_ctrl_btn_repeat #(
    .HOLD_CYC   (HOLD_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) u_btn_dn (
    .i_Sys_clk    (i_Sys_clk),
    .i_Rst_n      (i_Rst_n),
    .i_Btn        (i_Btn_down),
    .i_Force_idle (both_held),
    .o_Step       (dn_step),
    .o_Level      (dn_level)
  );

  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      target_q  <= RstV;
      cmd_q     <= RstV;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      s1_q      <= i_External_sync;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      target_q  <= target_d;
      cmd_q     <= cmd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
    end
  end

  assign commit = s2_q & ~s3_q;

  // Saturating step arithmetic, widened by one bit so the up-sum cannot wrap.
  always_comb begin
    tgt_x  = {1'b0, target_q};
    up_sum = tgt_x + StepX;
    up_val = (up_sum > MaxX) ? MaxV : up_sum[W-1:0];
    dn_val = (tgt_x < MinX + StepX) ? MinV : (target_q - StepV);
  end

  always_comb begin
    host_x   = {1'b0, i_Host_scaler};
    host_val = i_Host_scaler;
    clamped  = 1'b0;
    if (host_x < MinX) begin
      host_val = MinV;
      clamped  = 1'b1;
    end else if (host_x > MaxX) begin
      host_val = MaxV;
      clamped  = 1'b1;
    end
  end

  always_comb begin
    accept   = i_Host_valid & ready_q;
    target_d = target_q;
    // Host wins a same-cycle collision; the button step is dropped. Buttons are
    // also ignored while a host command is outstanding for this frame.
    if (accept) begin
      target_d = host_val;
    end else if (ready_q && up_step && !dn_step) begin
      target_d = up_val;
    end else if (ready_q && dn_step && !up_step) begin
      target_d = dn_val;
    end

    // One host command per frame: ready drops on accept and returns the cycle
    // after the next commit.
    busy_d    = accept | (busy_q & ~commit);
    ready_d   = ~busy_d;
    err_d     = accept & clamped;

    // Commit samples the registered target, so an update landing in the commit
    // cycle stays pending for the next frame.
    cmd_d     = commit ? target_q : cmd_q;
    upd_d     = commit & (target_q != cmd_q);
    pending_d = (target_q != cmd_q);
  end

  assign o_Host_ready   = ready_q;
  assign o_Host_err     = err_q;
  assign o_Cmd_scaler   = cmd_q;
  assign o_Pending      = pending_q;
  assign o_Update_pulse = upd_q;

endmodule
